// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, instruction-memory handshake and IF/ID register with branch/jump redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  selbrjumpz,
  input  logic [1:0]  selpctype,
  input  logic        compout,
  input  logic [31:0] rs_value,
  input  logic [31:0] imem_data,
  input  logic        imem_ready,
  output logic        imem_read,
  output logic [31:0] imem_addr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pcplus4,
  output logic        ifid_valid,
  output logic [5:0]  op,
  output logic [5:0]  fn
);
  typedef enum logic [1:0] {REQ, KILL, HOLD} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, pending_pc_q, pending_pc_d, hold_q, hold_d;
  logic [31:0] ifid_instr_q, ifid_instr_d, ifid_pcplus4_q, ifid_pcplus4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        redirect;
  logic [31:0] target, br_offset;
  assign br_offset = {{14{ifid_instr_q[15]}}, ifid_instr_q[15:0], 2'b00};
  assign redirect  = ifid_valid_q & ~stall & (selpctype != 2'b11) &
                     ((selbrjumpz == 2'b01) | ((selbrjumpz == 2'b10) & compout));
  assign target    = selpctype == 2'b00 ? ifid_pcplus4_q + br_offset :
                     selpctype == 2'b01 ? rs_value :
                     {ifid_pcplus4_q[31:28], ifid_instr_q[25:0], 2'b00};
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= REQ;
      pc_q           <= RESET_PC;
      pending_pc_q   <= '0;
      hold_q         <= '0;
      ifid_instr_q   <= '0;
      ifid_pcplus4_q <= '0;
      ifid_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      pending_pc_q   <= pending_pc_d;
      hold_q         <= hold_d;
      ifid_instr_q   <= ifid_instr_d;
      ifid_pcplus4_q <= ifid_pcplus4_d;
      ifid_valid_q   <= ifid_valid_d;
    end
  end
  // An unstalled ID slot always drains; it becomes a bubble unless a new instruction lands below.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pending_pc_d   = pending_pc_q;
    hold_d         = hold_q;
    ifid_instr_d   = stall ? ifid_instr_q : '0;
    ifid_pcplus4_d = ifid_pcplus4_q;
    ifid_valid_d   = stall ? ifid_valid_q : 1'b0;
    case (state_q)
      REQ: begin
        if (imem_ready) begin
          if (redirect) begin
            pc_d = target;
          end else if (stall) begin
            hold_d  = imem_data;
            state_d = HOLD;
          end else begin
            ifid_instr_d   = imem_data;
            ifid_pcplus4_d = pc_q + 32'd4;
            ifid_valid_d   = 1'b1;
            pc_d           = pc_q + 32'd4;
          end
        end else if (redirect) begin
          pending_pc_d = target;
          state_d      = KILL;
        end
      end
      KILL: begin
        if (imem_ready) begin
          pc_d    = pending_pc_q;
          state_d = REQ;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = REQ;
        end else if (!stall) begin
          ifid_instr_d   = hold_q;
          ifid_pcplus4_d = pc_q + 32'd4;
          ifid_valid_d   = 1'b1;
          pc_d           = pc_q + 32'd4;
          state_d        = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end
  always_comb begin
    imem_read = ~reset & (state_q != HOLD);
    imem_addr = pc_q;
  end
  assign ifid_instr   = ifid_instr_q;
  assign ifid_pcplus4 = ifid_pcplus4_q;
  assign ifid_valid   = ifid_valid_q;
  assign op           = ifid_instr_q[31:26];
  assign fn           = ifid_instr_q[5:0];
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed test-plan cases plus random traffic, checked by an instruction-stream scoreboard.
module tb_fetch_stage;
  localparam logic [31:0] RST = 32'h0000_0100;
  logic        clock = 1'b0, reset = 1'b1, stall = 1'b0, compout = 1'b0, imem_ready = 1'b1;
  logic [1:0]  selbrjumpz = 2'b00, selpctype = 2'b11;
  logic [31:0] rs_value = '0, imem_data;
  logic        imem_read, ifid_valid;
  logic [31:0] imem_addr, ifid_instr, ifid_pcplus4;
  logic [5:0]  op, fn;
  int checks = 0, fails = 0;

  fetch_stage #(.RESET_PC(RST)) dut (
    .clock(clock), .reset(reset), .stall(stall), .selbrjumpz(selbrjumpz), .selpctype(selpctype),
    .compout(compout), .rs_value(rs_value), .imem_data(imem_data), .imem_ready(imem_ready),
    .imem_read(imem_read), .imem_addr(imem_addr), .ifid_instr(ifid_instr),
    .ifid_pcplus4(ifid_pcplus4), .ifid_valid(ifid_valid), .op(op), .fn(fn)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a >= 32'h100 && a < 32'h110) return 32'h0022_1820;
    if (a == 32'h200) return 32'h1000_0003;
    if (a == 32'h4000_0000) return 32'h0800_0010;
    return (a ^ (a >> 7)) * 32'h9E37_79B1;
  endfunction
  assign imem_data = mem(imem_addr);

  function automatic logic taken(input logic [1:0] bj, input logic [1:0] pt, input logic c);
    return pt != 2'b11 && (bj == 2'b01 || (bj == 2'b10 && c));
  endfunction

  // Address of the instruction that must follow one leaving ID with these control inputs.
  function automatic logic [31:0] next_addr(input logic [31:0] pc4, input logic [31:0] instr,
                                            input logic [31:0] rs, input logic [1:0] bj,
                                            input logic [1:0] pt, input logic c);
    logic [31:0] off;
    if (!taken(bj, pt, c)) return pc4;
    off = 32'($signed(instr[15:0]));
    if (pt == 2'b00) return pc4 + off * 32'd4;
    if (pt == 2'b01) return rs;
    return {pc4[31:28], instr[25:0], 2'b00};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: queue holds the address of the next instruction expected in ID.
  logic [31:0] exp_q[$];
  initial begin
    logic prev_free, stale, hold_exp, redir;
    logic [31:0] a, exp_instr;
    int wait_cnt;
    prev_free = 1'b1; stale = 1'b0; hold_exp = 1'b0; exp_instr = '0; wait_cnt = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        chk("read_in_reset", 32'(imem_read), 32'd0);
        exp_q.delete();
        exp_q.push_back(RST);
        prev_free = 1'b1; stale = 1'b0; hold_exp = 1'b0; wait_cnt = 0;
      end else begin
        if (hold_exp) chk("hold_no_request", 32'(imem_read), 32'd0);
        if (!ifid_valid) chk("invalid_instr_zero", ifid_instr, 32'd0);
        else if (prev_free) begin
          if (exp_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_instr: got pc4 %h expected none", ifid_pcplus4);
          end else begin
            a = exp_q.pop_front();
            exp_instr = mem(a);
            chk("sb_pcplus4", ifid_pcplus4, a + 32'd4);
            chk("sb_instr", ifid_instr, exp_instr);
            chk("sb_op", 32'(op), 32'(exp_instr[31:26]));
            chk("sb_fn", 32'(fn), 32'(exp_instr[5:0]));
            wait_cnt = 0;
          end
        end else chk("stall_held", ifid_instr, exp_instr);
        redir = ifid_valid && !stall && taken(selbrjumpz, selpctype, compout);
        if (ifid_valid && !stall)
          exp_q.push_back(next_addr(ifid_pcplus4, ifid_instr, rs_value, selbrjumpz, selpctype, compout));
        hold_exp = imem_read && imem_ready && stall && !stale;
        if (imem_read && !imem_ready && redir) stale = 1'b1;
        else if (imem_read && imem_ready) stale = 1'b0;
        prev_free = !ifid_valid || !stall;
        if (exp_q.size() > 0) wait_cnt++;
        if (wait_cnt > 60) begin
          checks++; fails++;
          $display("FAIL delivery_timeout: got no instruction expected %h", exp_q[0]);
          wait_cnt = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic ctl(input logic [1:0] bj, input logic [1:0] pt, input logic c, input logic [31:0] rs);
    selbrjumpz = bj; selpctype = pt; compout = c; rs_value = rs;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock); chk("c0_addr", imem_addr, 32'h100); chk("c0_valid", 32'(ifid_valid), 0); step();
    @(negedge clock); chk("c1_addr", imem_addr, 32'h104); chk("c1_pc4", ifid_pcplus4, 32'h104);
    chk("c1_op", 32'(op), 0); chk("c1_fn", 32'(fn), 32'h20); step();
    ctl(2'b01, 2'b01, 1'b0, 32'h200);
    @(negedge clock); chk("c2_addr", imem_addr, 32'h108); step();
    ctl(2'b00, 2'b11, 1'b0, 0);
    @(negedge clock); chk("jr_addr", imem_addr, 32'h200); chk("jr_flush", 32'(ifid_valid), 0); step();
    ctl(2'b10, 2'b00, 1'b1, 0);
    @(negedge clock); chk("beq_seq", imem_addr, 32'h204); step();
    ctl(2'b00, 2'b11, 1'b0, 0);
    @(negedge clock); chk("beq_taken", imem_addr, 32'h210); chk("beq_valid", 32'(ifid_valid), 0);
    chk("beq_instr", ifid_instr, 0); step();
    ctl(2'b01, 2'b01, 1'b0, 32'h200); step();
    ctl(2'b00, 2'b11, 1'b0, 0); step();
    ctl(2'b10, 2'b00, 1'b0, 0);
    @(negedge clock); chk("beq2_pc4", ifid_pcplus4, 32'h204); step();
    ctl(2'b01, 2'b01, 1'b0, 32'h4000_0000);
    @(negedge clock); chk("beq_nt_addr", imem_addr, 32'h208); chk("beq_nt_valid", 32'(ifid_valid), 1); step();
    ctl(2'b00, 2'b11, 1'b0, 0); step();
    ctl(2'b01, 2'b10, 1'b0, 0);
    @(negedge clock); chk("j_pc4", ifid_pcplus4, 32'h4000_0004); step();
    ctl(2'b00, 2'b11, 1'b0, 0); imem_ready = 1'b0;
    @(negedge clock); chk("j_target", imem_addr, 32'h4000_0040); step();
    imem_ready = 1'b1;
    @(negedge clock); chk("wait_addr", imem_addr, 32'h4000_0040); step();
    imem_ready = 1'b0; ctl(2'b01, 2'b01, 1'b0, 32'h80);
    @(negedge clock); chk("kill_addr0", imem_addr, 32'h4000_0044); step();
    ctl(2'b00, 2'b11, 1'b0, 0);
    @(negedge clock); chk("kill_addr1", imem_addr, 32'h4000_0044); chk("kill_valid", 32'(ifid_valid), 0); step();
    imem_ready = 1'b1;
    @(negedge clock); chk("kill_addr2", imem_addr, 32'h4000_0044); step();
    @(negedge clock); chk("kill_target", imem_addr, 32'h80); chk("kill_discard", 32'(ifid_valid), 0); step();
    imem_ready = 1'b0; ctl(2'b01, 2'b01, 1'b0, 32'h300); step();
    ctl(2'b00, 2'b11, 1'b0, 0); reset = 1'b1; step();
    reset = 1'b0; imem_ready = 1'b1;
    @(negedge clock); chk("rst_kill_addr", imem_addr, RST); chk("rst_kill_valid", 32'(ifid_valid), 0); step();
    stall = 1'b1;
    @(negedge clock); chk("rst_kill_next", imem_addr, 32'h104); chk("st_pc4_0", ifid_pcplus4, 32'h104); step();
    @(negedge clock); chk("st_read_1", 32'(imem_read), 0); chk("st_pc4_1", ifid_pcplus4, 32'h104); step();
    @(negedge clock); chk("st_read_2", 32'(imem_read), 0); step();
    stall = 1'b0;
    @(negedge clock); chk("st_read_3", 32'(imem_read), 0); step();
    @(negedge clock); chk("st_release", ifid_pcplus4, 32'h108); chk("st_addr", imem_addr, 32'h108);
    chk("st_read_4", 32'(imem_read), 1); step();
    repeat (3000) begin
      reset      = $urandom % 100 == 0;
      stall      = $urandom % 4 == 0;
      imem_ready = $urandom % 10 < 6;
      selbrjumpz = 2'($urandom);
      selpctype  = 2'($urandom);
      compout    = 1'($urandom);
      rs_value   = $urandom & ~32'h3;
      step();
    end
    reset = 1'b0; stall = 1'b0; imem_ready = 1'b1; ctl(2'b00, 2'b11, 1'b0, 0);
    repeat (4) step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
